audio_sample_streamer: RTL and testbench

//  Prefetch stage between the packed sample ROM and the PWM audio generator.

---
 rtl/audio_sample_streamer.sv | 230 +++++++++++++++++++++++
 tb/tb_audio_sample_streamer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer: prefetches packed 32-bit sample words from the sample ROM, unpacks each
// word into two 16-bit PCM samples, buffers them in a small FIFO and hands one sample to the PWM
// stage per sample_tick.
//
// Build option: define STREAMER_UNDERRUN_MUTE_EN to force sample_o to midscale (16'h8000) on an
// underrun tick; without it sample_o holds its last value. The underrun flag is the same in both.

module audio_sample_streamer #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DEPTH     = 8,
  // All ones, i.e. 16'hFFFF at the default address width.
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aud_en,
  input  logic                     sample_tick,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  input  logic [31:0]              mem_data,
  output logic [15:0]              sample_o,
  output logic                     sample_valid,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned LvlW     = PtrW + 1;
  localparam logic [15:0] MidScale = 16'h8000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StPushLo,
    StPushHi
  } fetch_state_e;

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  fetch_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [31:0]          hold_q, hold_d;

  logic [15:0]          fifo_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]      level_q, level_d;

  logic [15:0]          sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 underrun_q, underrun_d;

  // FIFO write/read strobes shared between the fetch, pointer and pop logic.
  logic                 push;
  logic [15:0]          push_data;
  logic                 pop;

  // ---------------------------------------------------------------------------------------------
  // Fetch FSM: one ROM word per pass, split into low then high sample.
  // ---------------------------------------------------------------------------------------------

  // Next-state, holding register and word address; a low aud_en aborts any fetch in flight.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_data = hold_q[15:0];

    if (!aud_en) begin
      state_d = StIdle;
      addr_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          // Two free slots guarantee room for both halves, so pops never need to be awaited.
          if (level_q <= LvlW'(DEPTH - 2)) begin
            state_d = StReq;
          end
        end
        StReq: begin
          state_d = StWait;
        end
        StWait: begin
          hold_d  = mem_data;
          state_d = StPushLo;
        end
        StPushLo: begin
          push      = 1'b1;
          push_data = hold_q[15:0];
          state_d   = StPushHi;
        end
        StPushHi: begin
          push      = 1'b1;
          push_data = hold_q[31:16];
          addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
          state_d   = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Fetch state, address and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  // Read strobe is a decode of the registered state, so it is glitch-free and drops on reset.
  always_comb begin
    mem_rd   = (state_q == StReq);
    mem_addr = addr_q;
  end

  // ---------------------------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------------------------

  // Pop only against the registered level so a same-cycle push is never read back while empty.
  always_comb begin
    pop = aud_en && sample_tick && (level_q != '0);
  end

  // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (!aud_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // FIFO pointers and level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output path
  // ---------------------------------------------------------------------------------------------

  // Per-tick output update: pop on data, flag underrun when empty, flush when disabled.
  always_comb begin
    sample_d   = sample_q;
    valid_d    = 1'b0;
    underrun_d = underrun_q;

    if (!aud_en) begin
      sample_d   = MidScale;
      underrun_d = 1'b0;
    end else if (sample_tick) begin
      valid_d = 1'b1;
      if (level_q != '0) begin
        sample_d = fifo_q[rd_ptr_q];
      end else begin
        underrun_d = 1'b1;
`ifdef STREAMER_UNDERRUN_MUTE_EN
        sample_d   = MidScale;
`else
        sample_d   = sample_q;
`endif
      end
    end
  end

  // Registered sample, valid pulse and sticky underrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q   <= MidScale;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  // Output drive.
  always_comb begin
    sample_o     = sample_q;
    sample_valid = valid_q;
    underrun     = underrun_q;
    level        = level_q;
  end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Bench for audio_sample_streamer: directed phases plus a randomized phase, all checked every
// cycle against a queue-based reference model. Instantiated with LAST_ADDR=3 so wrap is visible.

module tb_audio_sample_streamer;

  localparam int unsigned DEPTH = 8;
  localparam logic [15:0] LAST  = 16'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        aud_en = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data = 32'h0;
  logic [15:0] sample_o;
  logic        sample_valid;
  logic        underrun;
  logic [3:0]  level;

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;

  // Reference model: FIFO contents as a queue, fetch progress as a cycle count within a fetch.
  logic [15:0] m_q[$];
  int          m_fetch;   // 0 = no fetch, 1 = read strobe cycle, 2 = data cycle, 3/4 = pushes
  logic [15:0] m_addr;
  logic [31:0] m_word;
  logic [15:0] m_sample;
  logic        m_valid;
  logic        m_underrun;

  audio_sample_streamer #(
    .ADDR_W   (16),
    .DEPTH    (DEPTH),
    .LAST_ADDR(LAST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .aud_en      (aud_en),
    .sample_tick (sample_tick),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .sample_o    (sample_o),
    .sample_valid(sample_valid),
    .underrun    (underrun),
    .level       (level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input logic [15:0] a);
    return {16'hA000 | {4'h0, a[11:0]}, 16'h5000 | {4'h0, a[11:0]}};
  endfunction

  // Sample memory: data for the strobed address appears one cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= pattern(mem_addr);
  end

  task automatic model_reset();
    m_q.delete();
    m_fetch    = 0;
    m_addr     = 16'h0;
    m_word     = 32'h0;
    m_sample   = 16'h8000;
    m_valid    = 1'b0;
    m_underrun = 1'b0;
  endtask

  // Advance the model across one clock edge given the inputs seen at that edge.
  task automatic model_edge(input logic en, input logic tick);
    int held;
    held = m_q.size();
    if (!en) begin
      model_reset();
      return;
    end
    m_valid = tick;
    if (tick) begin
      if (held > 0) m_sample = m_q.pop_front();
      else begin
        m_underrun = 1'b1;
`ifdef STREAMER_UNDERRUN_MUTE_EN
        m_sample = 16'h8000;
`endif
      end
    end
    if (m_fetch == 0) begin
      if (held <= int'(DEPTH) - 2) m_fetch = 1;
    end else if (m_fetch == 1) begin
      m_fetch = 2;
    end else if (m_fetch == 2) begin
      m_word  = pattern(m_addr);
      m_fetch = 3;
    end else if (m_fetch == 3) begin
      m_q.push_back(m_word[15:0]);
      m_fetch = 4;
    end else begin
      m_q.push_back(m_word[31:16]);
      m_addr  = (m_addr == LAST) ? 16'h0 : m_addr + 16'h1;
      m_fetch = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_rd", 32'(mem_rd), 32'(m_fetch == 1));
    check("sample_o", 32'(sample_o), 32'(m_sample));
    check("sample_valid", 32'(sample_valid), 32'(m_valid));
    check("underrun", 32'(underrun), 32'(m_underrun));
    check("level", 32'(level), 32'(m_q.size()));
  endtask

  // One clock: drive inputs, let the edge pass, update the model, sample 1 time unit later.
  task automatic step(input logic en, input logic tick);
    aud_en      = en;
    sample_tick = tick;
    @(posedge clk);
    model_edge(en, tick);
    #1;
    if (mem_rd) rd_cnt++;
    check_all();
  endtask

  initial begin
    int   k;
    logic found;
    logic [31:0] exp_s;

    // Reset values, during reset and after the first clock in reset.
    model_reset();
    #1 rst = 1'b1;
    #2 check_all();
    @(posedge clk);
    #1 check_all();
    rst = 1'b0;

    // Enable with no ticks: FIFO fills to DEPTH with exactly four reads at 0..3.
    rd_cnt = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    check("fill_rd_count", 32'(rd_cnt), 32'd4);
    check("fill_level", 32'(level), 32'(DEPTH));

    // Slow ticks: samples in order, wrapping after word 3.
    k = 0;
    for (int t = 0; t < 10; t++) begin
      step(1'b1, 1'b1);
      exp_s = (k % 2 == 0) ? (32'h5000 | 32'((k / 2) % 4)) : (32'hA000 | 32'((k / 2) % 4));
      check("seq_sample", 32'(sample_o), exp_s);
      check("seq_valid", 32'(sample_valid), 32'd1);
      k++;
      for (int i = 0; i < 19; i++) step(1'b1, 1'b0);
    end

    // Randomized enable/tick traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0);
    end

    // Tick every cycle until the FIFO runs dry.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    check("drain_underrun", 32'(underrun), 32'd1);

    // Drop enable during the data cycle of a fetch.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_fetch == 2) begin
        found = 1'b1;
        break;
      end
      step(1'b1, 1'b0);
    end
    check("reach_wait", 32'(found), 32'd1);
    step(1'b0, 1'b0);
    check("drop_level", 32'(level), 32'd0);
    check("drop_addr", 32'(mem_addr), 32'd0);
    check("drop_sample", 32'(sample_o), 32'h8000);
    check("drop_underrun", 32'(underrun), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check("drop_no_push", 32'(level), 32'd0);
    step(1'b1, 1'b0);
    check("reen_rd", 32'(mem_rd), 32'd1);
    check("reen_addr", 32'(mem_addr), 32'd0);

    // Asynchronous reset while the high half is being pushed.
    for (int i = 0; i < 30; i++) step(1'b1, $urandom_range(0, 1) == 1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_fetch == 4) begin
        found = 1'b1;
        break;
      end
      step(1'b1, 1'b0);
    end
    check("reach_push_hi", 32'(found), 32'd1);
    #1 rst = 1'b1;
    model_reset();
    #1 check_all();
    #1 rst = 1'b0;
    for (int i = 0; i < 60; i++) step(1'b1, $urandom_range(0, 2) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
